// File: rtl/apb_req_bridge.sv
// Request/grant/response to APB3 master bridge: one transfer in flight,
// with a wait-state watchdog that aborts a hung access with an error response.
module apb_req_bridge #(
  parameter int unsigned               APB_ADDR_WIDTH = 32,
  parameter int unsigned               APB_DATA_WIDTH = 32,
  parameter int unsigned               TIMEOUT        = 256,
  parameter logic [APB_DATA_WIDTH-1:0] ERR_RDATA      = APB_DATA_WIDTH'(32'hBADACCE5)
) (
  input  logic                      ACLK_i,
  input  logic                      ARESET_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] add_i,
  input  logic                      we_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      r_valid_o,
  output logic [APB_DATA_WIDTH-1:0] r_rdata_o,
  output logic                      r_opc_o,
  output logic                      PSEL_o,
  output logic                      PENABLE_o,
  output logic                      PWRITE_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR_o,
  output logic [APB_DATA_WIDTH-1:0] PWDATA_o,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA_i,
  input  logic                      PREADY_i,
  input  logic                      PSLVERR_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic                      write;
    logic [APB_DATA_WIDTH-1:0] wdata;
  } apb_req_t;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  apb_req_t                  req_q, req_d;
  logic                      psel_q, psel_d;
  logic                      penable_q, penable_d;
  logic                      r_valid_q, r_valid_d;
  logic [APB_DATA_WIDTH-1:0] r_rdata_q, r_rdata_d;
  logic                      r_opc_q, r_opc_d;

  // State and output registers
  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      r_valid_q <= 1'b0;
      r_rdata_q <= '0;
      r_opc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      r_valid_q <= r_valid_d;
      r_rdata_q <= r_rdata_d;
      r_opc_q   <= r_opc_d;
    end
  end

  // Next-state and grant logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    r_valid_d = 1'b0;
    r_rdata_d = r_rdata_q;
    r_opc_d   = r_opc_q;
    gnt_o     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gnt_o = req_i;
        if (req_i) begin
          req_d.addr  = add_i;
          req_d.write = we_i;
          req_d.wdata = wdata_i;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        // Slave completion takes priority over a watchdog abort in the same cycle
        if (PREADY_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          r_valid_d = 1'b1;
          r_rdata_d = req_q.write ? '0 : PRDATA_i;
          r_opc_d   = PSLVERR_i;
          state_d   = ST_IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          r_valid_d = 1'b1;
          r_rdata_d = req_q.write ? '0 : ERR_RDATA;
          r_opc_d   = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  assign PSEL_o    = psel_q;
  assign PENABLE_o = penable_q;
  assign PWRITE_o  = req_q.write;
  assign PADDR_o   = req_q.addr;
  assign PWDATA_o  = req_q.wdata;
  assign r_valid_o = r_valid_q;
  assign r_rdata_o = r_rdata_q;
  assign r_opc_o   = r_opc_q;

endmodule

// File: tb/tb_apb_req_bridge.sv
// Directed bench for apb_req_bridge; inputs change and outputs are sampled
// around the falling edge, away from the rising active edge.
module tb_apb_req_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic [31:0] add_i;
  logic        we_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        r_valid_o;
  logic [31:0] r_rdata_o;
  logic        r_opc_o;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_req_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT(4),
    .ERR_RDATA(32'hBADACCE5)
  ) dut (
    .ACLK_i(clk),
    .ARESET_i(rst),
    .req_i(req_i),
    .add_i(add_i),
    .we_i(we_i),
    .wdata_i(wdata_i),
    .gnt_o(gnt_o),
    .r_valid_o(r_valid_o),
    .r_rdata_o(r_rdata_o),
    .r_opc_o(r_opc_o),
    .PSEL_o(psel),
    .PENABLE_o(penable),
    .PWRITE_o(pwrite),
    .PADDR_o(paddr),
    .PWDATA_o(pwdata),
    .PRDATA_i(prdata),
    .PREADY_i(pready),
    .PSLVERR_i(pslverr)
  );

  task automatic test_reset();
    rst = 1'b1; req_i = 1'b0; add_i = '0; we_i = 1'b0; wdata_i = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({gnt_o, r_valid_o, r_opc_o, psel, penable, pwrite} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {gnt_o, r_valid_o, r_opc_o, psel, penable, pwrite}); end
    checks++; if ({paddr, pwdata, r_rdata_o} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, r_rdata_o}); end
  endtask

  task automatic test_zero_wait_read();
    @(negedge clk);
    req_i = 1'b1; add_i = 32'h1A10_0004; we_i = 1'b0; wdata_i = 32'h1111_2222;
    prdata = 32'hCAFE_F00D; pready = 1'b1; #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt_T: got %b expected 1", gnt_o); end
    @(negedge clk); req_i = 1'b0; #1;
    checks++; if ({psel, penable} !== 2'b10) begin errors++; $display("FAIL rd_setup: got %b expected 10", {psel, penable}); end
    checks++; if (paddr !== 32'h1A10_0004 || pwrite !== 1'b0) begin errors++; $display("FAIL rd_paddr: got %h/%b expected 1a100004/0", paddr, pwrite); end
    @(negedge clk); #1;
    checks++; if ({psel, penable, r_valid_o} !== 3'b110) begin errors++; $display("FAIL rd_access: got %b expected 110", {psel, penable, r_valid_o}); end
    @(negedge clk); pready = 1'b0; prdata = 32'h0; #1;
    checks++; if ({r_valid_o, r_opc_o, psel} !== 3'b100) begin errors++; $display("FAIL rd_resp_flags: got %b expected 100", {r_valid_o, r_opc_o, psel}); end
    checks++; if (r_rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_resp_data: got %h expected cafef00d", r_rdata_o); end
    @(negedge clk); #1;
    checks++; if (r_valid_o !== 1'b0 || r_rdata_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_hold: got %b/%h expected 0/cafef00d", r_valid_o, r_rdata_o); end
  endtask

  task automatic test_write_wait_err();
    @(negedge clk);
    req_i = 1'b1; add_i = 32'h1A10_2000; we_i = 1'b1; wdata_i = 32'h55AA_55AA;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF; #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b expected 1", gnt_o); end
    @(negedge clk); req_i = 1'b0; wdata_i = 32'h0; #1;
    checks++; if (pwrite !== 1'b1 || pwdata !== 32'h55AA_55AA) begin errors++; $display("FAIL wr_setup: got %b/%h expected 1/55aa55aa", pwrite, pwdata); end
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) begin pready = 1'b1; pslverr = 1'b1; end
      #1;
      checks++; if ({psel, penable, r_valid_o} !== 3'b110 || pwdata !== 32'h55AA_55AA) begin errors++; $display("FAIL wr_access_T%0d: got %b/%h expected 110/55aa55aa", k, {psel, penable, r_valid_o}, pwdata); end
    end
    @(negedge clk); pready = 1'b0; pslverr = 1'b0; #1;
    checks++; if ({r_valid_o, r_opc_o, psel} !== 3'b110 || r_rdata_o !== 32'h0) begin errors++; $display("FAIL wr_resp_T6: got %b/%h expected 110/00000000", {r_valid_o, r_opc_o, psel}, r_rdata_o); end
  endtask

  task automatic test_timeout(input logic late_ready);
    @(negedge clk);
    req_i = 1'b1; add_i = 32'h1A10_3000; we_i = 1'b0; wdata_i = 32'h0;
    pready = 1'b0; prdata = 32'h1234_5678; #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL to_gnt_%0d: got %b expected 1", late_ready, gnt_o); end
    @(negedge clk); req_i = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) pready = late_ready;
      #1;
      checks++; if ({psel, penable, r_valid_o} !== 3'b110) begin errors++; $display("FAIL to_access_%0d_T%0d: got %b expected 110", late_ready, k, {psel, penable, r_valid_o}); end
    end
    @(negedge clk); pready = 1'b0; #1;
    if (late_ready) begin
      checks++; if ({r_valid_o, r_opc_o, psel} !== 3'b100 || r_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL to_late_ready: got %b/%h expected 100/12345678", {r_valid_o, r_opc_o, psel}, r_rdata_o); end
    end else begin
      checks++; if ({r_valid_o, r_opc_o, psel} !== 3'b110 || r_rdata_o !== 32'hBADACCE5) begin errors++; $display("FAIL to_abort: got %b/%h expected 110/badacce5", {r_valid_o, r_opc_o, psel}, r_rdata_o); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] datas [3];
    addrs = '{32'h1A10_0100, 32'h1A10_0200, 32'h1A10_0300};
    datas = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
    @(negedge clk);
    we_i = 1'b0; pready = 1'b1; pslverr = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge clk);
      req_i = (c < 9);
      add_i = addrs[(c < 9) ? c / 3 : 2];
      prdata = datas[(c < 9) ? c / 3 : 2];
      #1;
      checks++; if (gnt_o !== (c % 3 == 0 && c < 9)) begin errors++; $display("FAIL b2b_gnt_T%0d: got %b expected %b", c, gnt_o, (c % 3 == 0 && c < 9)); end
      checks++; if (r_valid_o !== (c % 3 == 0 && c > 0)) begin errors++; $display("FAIL b2b_rvalid_T%0d: got %b expected %b", c, r_valid_o, (c % 3 == 0 && c > 0)); end
      if (c > 0 && c % 3 != 0) begin
        checks++; if (paddr !== addrs[(c - 1) / 3]) begin errors++; $display("FAIL b2b_paddr_T%0d: got %h expected %h", c, paddr, addrs[(c - 1) / 3]); end
      end
      if (c > 0 && c % 3 == 0) begin
        checks++; if (r_rdata_o !== datas[c / 3 - 1]) begin errors++; $display("FAIL b2b_rdata_T%0d: got %h expected %h", c, r_rdata_o, datas[c / 3 - 1]); end
      end
    end
    pready = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    req_i = 1'b1; add_i = 32'h1A10_4000; we_i = 1'b1; wdata_i = 32'h7777_8888; pready = 1'b0; #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_gnt: got %b expected 1", gnt_o); end
    @(negedge clk); req_i = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL rst_pre_access: got %b expected 11", {psel, penable}); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({gnt_o, r_valid_o, r_opc_o, psel, penable, pwrite} !== 6'b0) begin errors++; $display("FAIL rst_mid_ctrl: got %b expected 000000", {gnt_o, r_valid_o, r_opc_o, psel, penable, pwrite}); end
    checks++; if ({paddr, pwdata, r_rdata_o} !== 96'h0) begin errors++; $display("FAIL rst_mid_data: got %h expected 0", {paddr, pwdata, r_rdata_o}); end
    @(negedge clk); #1;
    checks++; if (r_valid_o !== 1'b0 || psel !== 1'b0) begin errors++; $display("FAIL rst_no_resp: got %b/%b expected 0/0", r_valid_o, psel); end
    req_i = 1'b1; add_i = 32'h1A10_4004; we_i = 1'b1; wdata_i = 32'h0F0F_0F0F; pready = 1'b1; #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_after_gnt: got %b expected 1", gnt_o); end
    @(negedge clk); req_i = 1'b0; #1;
    checks++; if ({psel, pwrite, pwdata} !== {2'b11, 32'h0F0F_0F0F}) begin errors++; $display("FAIL rst_after_setup: got %b%b/%h expected 11/0f0f0f0f", psel, pwrite, pwdata); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({r_valid_o, r_opc_o} !== 2'b10 || r_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_after_resp: got %b/%h expected 10/00000000", {r_valid_o, r_opc_o}, r_rdata_o); end
    pready = 1'b0;
  endtask

  task automatic test_busy_ignore();
    @(negedge clk);
    req_i = 1'b1; add_i = 32'h1A10_5000; we_i = 1'b0; pready = 1'b0; prdata = 32'h5A5A_A5A5; #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL busy_gnt: got %b expected 1", gnt_o); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_i = k[0];
      add_i = 32'hFFFF_0000 + 32'(k);
      we_i = 1'b1;
      if (k == 4) pready = 1'b1;
      #1;
      checks++; if (gnt_o !== 1'b0 || paddr !== 32'h1A10_5000) begin errors++; $display("FAIL busy_T%0d: got %b/%h expected 0/1a105000", k, gnt_o, paddr); end
    end
    @(negedge clk); req_i = 1'b0; pready = 1'b0; #1;
    checks++; if ({r_valid_o, r_opc_o} !== 2'b10 || r_rdata_o !== 32'h5A5A_A5A5) begin errors++; $display("FAIL busy_resp: got %b/%h expected 10/5a5aa5a5", {r_valid_o, r_opc_o}, r_rdata_o); end
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_wait_err();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_back_to_back();
    test_reset_mid_access();
    test_busy_ignore();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
